// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
// Phase encoding, PIO tags, op codes and op classification helpers.
package calc_pkg;

  typedef enum logic [3:0] {
    PH_ENTER_A = 4'd0,
    PH_SEL_OP  = 4'd1,
    PH_ENTER_B = 4'd2,
    PH_BUSY    = 4'd3,
    PH_SHOW    = 4'd4,
    PH_ERR     = 4'd5
  } phase_e;

  localparam logic [2:0] TAG_CLR   = 3'b111;
  localparam logic [2:0] TAG_A     = 3'b001;
  localparam logic [2:0] TAG_OP    = 3'b010;
  localparam logic [2:0] TAG_UNARY = 3'b011;
  localparam logic [2:0] TAG_B     = 3'b100;
  localparam logic [2:0] TAG_CHAIN = 3'b101;

  localparam logic [9:0] OP_ADD  = 10'b0000000001;
  localparam logic [9:0] OP_SUB  = 10'b0000000010;
  localparam logic [9:0] OP_MUL  = 10'b0000000100;
  localparam logic [9:0] OP_DIV  = 10'b0000001000;
  localparam logic [9:0] OP_POW  = 10'b1000000010;
  localparam logic [9:0] OP_LOG2 = 10'b1000000001;
  localparam logic [9:0] OP_FACT = 10'b1000000100;
  localparam logic [9:0] OP_D2R  = 10'b1000001000;

  function automatic logic is_unary(input logic [9:0] op);
    return (op == OP_LOG2) || (op == OP_FACT) ||
           (op == OP_D2R);
  endfunction

  function automatic logic is_valid_op(input logic [9:0] op);
    return is_unary(op) ||
           (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MUL) || (op == OP_DIV) ||
           (op == OP_POW);
  endfunction

endpackage

// File: rtl/bttn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, optional debounce, press pulse.
// Debounce is enabled by defining CALC_SEQ_DEBOUNCE_EN.
module bttn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bttn_ni,
  output logic press_o
);

  logic s1_q;
  logic s2_q;

  // Synchronize the raw button; idle level is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= bttn_ni;
      s2_q <= s1_q;
    end
  end

`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          flip;

  assign flip    = (s2_q != stable_q) &&
                   (cnt_q == CMAX);
  assign press_o = flip && !s2_q;

  // Accept a new level only after an unbroken run of samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else if (s2_q == stable_q) begin
      cnt_q    <= '0;
    end else if (flip) begin
      stable_q <= s2_q;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  logic prev_q;

  assign press_o = prev_q && !s2_q;

  // Previous synchronized level for falling-edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b1;
    else       prev_q <= s2_q;
  end
`endif

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer FSM: operand capture, ALU launch, PIO tagging.
// Define CALC_SEQ_DEBOUNCE_EN to debounce the pushbuttons.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CALC_TIMEOUT    = 65535
) (
  input  logic        fifty_MHz,
  input  logic        reset,
  input  logic        bttn0,
  input  logic        bttn1,
  input  logic [9:0]  sw,
  input  logic [19:0] entry_val,
  input  logic        calc_done,
  input  logic [19:0] calc_result,
  output logic [19:0] op_a,
  output logic [19:0] op_b,
  output logic [9:0]  op_sel,
  output logic        calc_start,
  output logic [3:0]  phase,
  output logic        entry_clr,
  output logic [22:0] pio_word,
  output logic        pio_valid,
  output logic        err
);

  localparam int TW = $clog2(CALC_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST =
    TW'(CALC_TIMEOUT - 1);

  logic p0;
  logic p1;

  bttn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_b0 (
    .clk_i  (fifty_MHz),
    .rst_i  (reset),
    .bttn_ni(bttn0),
    .press_o(p0)
  );

  bttn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_b1 (
    .clk_i  (fifty_MHz),
    .rst_i  (reset),
    .bttn_ni(bttn1),
    .press_o(p1)
  );

  phase_e        state_q, state_d;
  logic [19:0]   op_a_q, op_a_d;
  logic [19:0]   op_b_q, op_b_d;
  logic [9:0]    op_sel_q, op_sel_d;
  logic [19:0]   res_q, res_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          clr_q, clr_d;
  logic [22:0]   pw_q, pw_d;
  logic          pv_q, pv_d;

  // All state and registered outputs.
  always_ff @(posedge fifty_MHz or posedge reset) begin
    if (reset) begin
      state_q  <= PH_ENTER_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      res_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      clr_q    <= 1'b0;
      pw_q     <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      res_q    <= res_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      start_q  <= start_d;
      clr_q    <= clr_d;
      pw_q     <= pw_d;
      pv_q     <= pv_d;
    end
  end

  // Next-state logic; clear (p0) overrides every state and p1.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sel_d = op_sel_q;
    res_d    = res_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    start_d  = 1'b0;
    clr_d    = 1'b0;
    pw_d     = pw_q;
    pv_d     = 1'b0;
    if (p0) begin
      state_d  = PH_ENTER_A;
      op_a_d   = '0;
      op_b_d   = '0;
      op_sel_d = '0;
      err_d    = 1'b0;
      clr_d    = 1'b1;
      pw_d     = {TAG_CLR, 20'd0};
      pv_d     = 1'b1;
    end else begin
      unique case (state_q)
        PH_ENTER_A: if (p1) begin
          op_a_d  = entry_val;
          pw_d    = {TAG_A, entry_val};
          pv_d    = 1'b1;
          clr_d   = 1'b1;
          state_d = PH_SEL_OP;
        end
        PH_SEL_OP: if (p1 && is_valid_op(sw)) begin
          op_sel_d = sw;
          pv_d     = 1'b1;
          if (is_unary(sw)) begin
            pw_d    = {TAG_UNARY, 10'd0, sw};
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = PH_BUSY;
          end else begin
            pw_d    = {TAG_OP, 10'd0, sw};
            state_d = PH_ENTER_B;
          end
        end
        PH_ENTER_B: if (p1) begin
          op_b_d = entry_val;
          pw_d   = {TAG_B, entry_val};
          pv_d   = 1'b1;
          if (op_sel_q == OP_DIV &&
              entry_val == 20'd0) begin
            err_d   = 1'b1;
            state_d = PH_ERR;
          end else begin
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = PH_BUSY;
          end
        end
        PH_BUSY: begin
          if (calc_done) begin
            res_d   = calc_result;
            state_d = PH_SHOW;
          end else if (tmo_q == TLAST) begin
            err_d   = 1'b1;
            state_d = PH_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        PH_SHOW: if (p1) begin
          op_a_d  = res_q;
          pw_d    = {TAG_CHAIN, 20'd0};
          pv_d    = 1'b1;
          state_d = PH_SEL_OP;
        end
        PH_ERR: ;
        default: state_d = PH_ENTER_A;
      endcase
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_sel     = op_sel_q;
  assign calc_start = start_q;
  assign phase      = state_q;
  assign entry_clr  = clr_q;
  assign pio_word   = pw_q;
  assign pio_valid  = pv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
// Runs with CALC_SEQ_DEBOUNCE_EN undefined and a short timeout.
module tb_calc_sequencer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bttn0 = 1'b1;
  logic        bttn1 = 1'b1;
  logic [9:0]  sw = '0;
  logic [19:0] entry_val = '0;
  logic        calc_done = 1'b0;
  logic [19:0] calc_result = '0;
  logic [19:0] op_a;
  logic [19:0] op_b;
  logic [9:0]  op_sel;
  logic        calc_start;
  logic [3:0]  phase;
  logic        entry_clr;
  logic [22:0] pio_word;
  logic        pio_valid;
  logic        err;

  int errors = 0;
  int checks = 0;

  calc_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CALC_TIMEOUT   (TMO)
  ) dut (
    .fifty_MHz  (clk),
    .reset      (reset),
    .bttn0      (bttn0),
    .bttn1      (bttn1),
    .sw         (sw),
    .entry_val  (entry_val),
    .calc_done  (calc_done),
    .calc_result(calc_result),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sel     (op_sel),
    .calc_start (calc_start),
    .phase      (phase),
    .entry_clr  (entry_clr),
    .pio_word   (pio_word),
    .pio_valid  (pio_valid),
    .err        (err)
  );

  always #10 clk = ~clk;

  logic [22:0] pio_log [64];
  int pio_wr = 0;
  int starts = 0;
  int clrs = 0;
  int rd = 0;

  always @(posedge clk) begin
    if (pio_valid) begin
      pio_log[pio_wr[5:0]] <= pio_word;
      pio_wr <= pio_wr + 1;
    end
    if (calc_start) starts <= starts + 1;
    if (entry_clr)  clrs <= clrs + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_pio(input string tag,
                            input logic [2:0] t,
                            input logic [19:0] pl);
    logic [22:0] w;
    w = 'x;
    if (rd < pio_wr) begin
      w = pio_log[rd[5:0]];
      rd++;
    end
    chk(tag, {9'd0, w}, {9'd0, t, pl});
  endtask

  task automatic press(input bit b0, input bit b1);
    @(negedge clk);
    if (b0) bttn0 = 1'b0;
    if (b1) bttn1 = 1'b0;
    repeat (4) @(negedge clk);
    bttn0 = 1'b1;
    bttn1 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic done(input logic [19:0] v);
    @(negedge clk);
    calc_done   = 1'b1;
    calc_result = v;
    @(negedge clk);
    calc_done = 1'b0;
  endtask

  int s0;
  int c0;
  int w0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_phase", {28'd0, phase}, 32'd0);
    chk("rst_opa", {12'd0, op_a}, 32'd0);
    chk("rst_pio", {9'd0, pio_word}, 32'd0);
    chk("rst_ctl", {28'd0, pio_valid, err,
                    calc_start, entry_clr}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // add chain
    c0 = clrs;
    entry_val = 20'd12;
    press(0, 1);
    chk("a_phase", {28'd0, phase}, 32'd1);
    chk("a_opa", {12'd0, op_a}, 32'd12);
    chk("a_clr", clrs - c0, 1);
    expect_pio("a_pio", 3'b001, 20'd12);
    sw = 10'b0000000001;
    press(0, 1);
    chk("op_phase", {28'd0, phase}, 32'd2);
    chk("op_sel", {22'd0, op_sel}, 32'd1);
    expect_pio("op_pio", 3'b010, 20'd1);
    s0 = starts;
    entry_val = 20'd30;
    press(0, 1);
    chk("b_phase", {28'd0, phase}, 32'd3);
    chk("b_opb", {12'd0, op_b}, 32'd30);
    chk("b_start", starts - s0, 1);
    expect_pio("b_pio", 3'b100, 20'd30);
    @(negedge clk);
    calc_done   = 1'b1;
    calc_result = 20'd42;
    @(posedge clk);
    #1;
    chk("done_show", {28'd0, phase}, 32'd4);
    @(negedge clk);
    calc_done = 1'b0;

    // chaining
    press(0, 1);
    chk("ch_phase", {28'd0, phase}, 32'd1);
    chk("ch_opa", {12'd0, op_a}, 32'd42);
    expect_pio("ch_pio", 3'b101, 20'd0);

    // invalid op code
    w0 = pio_wr;
    sw = 10'b0000000011;
    press(0, 1);
    chk("inv_phase", {28'd0, phase}, 32'd1);
    chk("inv_nopio", pio_wr - w0, 0);

    // clear
    press(1, 0);
    chk("clr_phase", {28'd0, phase}, 32'd0);
    chk("clr_opa", {12'd0, op_a}, 32'd0);
    expect_pio("clr_pio", 3'b111, 20'd0);

    // unary factorial
    entry_val = 20'd5;
    press(0, 1);
    expect_pio("u_a_pio", 3'b001, 20'd5);
    s0 = starts;
    sw = 10'b1000000100;
    press(0, 1);
    chk("u_phase", {28'd0, phase}, 32'd3);
    chk("u_start", starts - s0, 1);
    expect_pio("u_pio", 3'b011, 20'h00204);
    done(20'd120);
    chk("u_show", {28'd0, phase}, 32'd4);
    done(20'd7);
    chk("stray_done", {28'd0, phase}, 32'd4);
    press(0, 1);
    chk("u_chain", {12'd0, op_a}, 32'd120);
    expect_pio("u_ch_pio", 3'b101, 20'd0);

    // divide by zero
    press(1, 0);
    expect_pio("dz_clr", 3'b111, 20'd0);
    entry_val = 20'd9;
    press(0, 1);
    expect_pio("dz_a", 3'b001, 20'd9);
    sw = 10'b0000001000;
    press(0, 1);
    expect_pio("dz_op", 3'b010, 20'd8);
    s0 = starts;
    entry_val = 20'd0;
    press(0, 1);
    chk("dz_phase", {28'd0, phase}, 32'd5);
    chk("dz_err", {31'd0, err}, 32'd1);
    chk("dz_nostart", starts - s0, 0);
    expect_pio("dz_b", 3'b100, 20'd0);
    w0 = pio_wr;
    press(0, 1);
    chk("err_p1", {28'd0, phase}, 32'd5);
    chk("err_nopio", pio_wr - w0, 0);
    press(1, 0);
    chk("err_clr", {28'd0, phase}, 32'd0);
    chk("err_low", {31'd0, err}, 32'd0);
    expect_pio("err_pio", 3'b111, 20'd0);

    // simultaneous p0/p1 in ENTER_B
    entry_val = 20'd1;
    press(0, 1);
    expect_pio("sim_a", 3'b001, 20'd1);
    sw = 10'b0000000001;
    press(0, 1);
    expect_pio("sim_op", 3'b010, 20'd1);
    w0 = pio_wr;
    entry_val = 20'd7;
    press(1, 1);
    chk("sim_phase", {28'd0, phase}, 32'd0);
    chk("sim_n", pio_wr - w0, 1);
    chk("sim_opb", {12'd0, op_b}, 32'd0);
    expect_pio("sim_pio", 3'b111, 20'd0);

    // reset during BUSY
    entry_val = 20'd3;
    press(0, 1);
    press(0, 1);
    press(0, 1);
    chk("rb_busy", {28'd0, phase}, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rb_phase", {28'd0, phase}, 32'd0);
    chk("rb_opa", {12'd0, op_a}, 32'd0);
    chk("rb_pio", {9'd0, pio_word}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done(20'd99);
    chk("rb_done", {28'd0, phase}, 32'd0);
    rd = pio_wr;

    // timeout
    entry_val = 20'd4;
    press(0, 1);
    press(0, 1);
    press(0, 1);
    repeat (5) @(negedge clk);
    chk("to_busy", {28'd0, phase}, 32'd3);
    repeat (TMO) @(negedge clk);
    chk("to_phase", {28'd0, phase}, 32'd5);
    chk("to_err", {31'd0, err}, 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
